// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage.
//   - RV32 base opcodes handled by the decoder
//   - control field widths and the memread bit position
//   - ctl_t: packed {wb[1:0], m[2:0], ex[2:0]} bundle carried into EX
//   - per-format control words and immediate-format selector
package id_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int WB_W = 2;  // {regwrite, memtoreg}
  localparam int M_W  = 3;  // {branch, memread, memwrite}
  localparam int EX_W = 3;  // {alusrc, aluop[1:0]}

  localparam int M_MEMREAD = 1;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctl_t;

  localparam ctl_t CTL_NONE   = '{wb: 2'b00, m: 3'b000, ex: 3'b000};
  localparam ctl_t CTL_R      = '{wb: 2'b10, m: 3'b000, ex: 3'b010};
  localparam ctl_t CTL_I      = '{wb: 2'b10, m: 3'b000, ex: 3'b110};
  localparam ctl_t CTL_LOAD   = '{wb: 2'b11, m: 3'b010, ex: 3'b100};
  localparam ctl_t CTL_STORE  = '{wb: 2'b00, m: 3'b001, ex: 3'b100};
  localparam ctl_t CTL_BRANCH = '{wb: 2'b00, m: 3'b100, ex: 3'b001};

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } imm_sel_e;

endpackage

// File: rtl/id_regfile.sv
// Architectural register file for the decode stage.
//   clk_i, rst_i          : clock, asynchronous active-high clear of all registers
//   we_i, waddr_i, wdata_i: writeback port (writes to register 0 are dropped)
//   raddr1_i, raddr2_i    : combinational read addresses
//   rdata1_o, rdata2_o    : read data; register 0 reads 0, a same-cycle write
//                           to the addressed register is forwarded
module id_regfile #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int RA    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [RA-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [RA-1:0]   raddr1_i,
  input  logic [RA-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Write-through lets an instruction in ID see the value WB is writing this cycle.
  assign rdata1_o = (raddr1_i == '0)                     ? '0      :
                    (we_i && (waddr_i == raddr1_i))      ? wdata_i :
                                                           regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0)                     ? '0      :
                    (we_i && (waddr_i == raddr2_i))      ? wdata_i :
                                                           regs_q[raddr2_i];

endmodule

// File: rtl/id_stage_hz.sv
// RV32-style instruction-decode stage with load-use hazard detection.
//   clock, reset          : clock, asynchronous active-high reset
//   if_id_*               : instruction, PC+4 and valid from the IF/ID register
//   wb_*                  : register writeback from WB
//   flush                 : branch taken in EX, kill the instruction in ID
//   stall, illegal        : combinational hold request / unknown-opcode flag
//   id_ex_valid .. rd_out : registered ID/EX pipeline contents for EX
module id_stage_hz
  import id_pkg::*;
#(
  parameter  int              XLEN     = 32,
  parameter  int              NREGS    = 32,
  parameter  logic [XLEN-1:0] RESET_PC = '0,
  localparam int              RA       = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instruction,
  input  logic [XLEN-1:0] if_id_npc,
  input  logic            wb_regwrite,
  input  logic [RA-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_writedata,
  input  logic            flush,
  output logic            stall,
  output logic            illegal,
  output logic            id_ex_valid,
  output logic [1:0]      wb_ctl,
  output logic [2:0]      m_ctl,
  output logic [2:0]      ex_ctl,
  output logic [XLEN-1:0] npc_out,
  output logic [XLEN-1:0] rdata1_out,
  output logic [XLEN-1:0] rdata2_out,
  output logic [XLEN-1:0] imm_out,
  output logic [RA-1:0]   rs1_out,
  output logic [RA-1:0]   rs2_out,
  output logic [RA-1:0]   rd_out
);

  logic [31:0]   instr;
  logic [6:0]    opcode;
  logic [RA-1:0] rs1, rs2, rd;
  logic          unused_instr_bits;

  assign instr  = if_id_instruction;
  assign opcode = instr[6:0];
  assign rd     = instr[7 +: RA];
  assign rs1    = instr[15 +: RA];
  assign rs2    = instr[20 +: RA];
  // funct3/funct7 (and index bits above RA) do not affect this stage.
  assign unused_instr_bits = ^instr;

  // Control decode
  ctl_t     ctl_dec;
  imm_sel_e imm_sel;
  logic     legal, rs2_used;

  always_comb begin
    ctl_dec  = CTL_NONE;
    imm_sel  = IMM_NONE;
    legal    = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_R:      begin ctl_dec = CTL_R;                          rs2_used = 1'b1; end
      OP_I:      begin ctl_dec = CTL_I;      imm_sel = IMM_I;                     end
      OP_LOAD:   begin ctl_dec = CTL_LOAD;   imm_sel = IMM_I;                     end
      OP_STORE:  begin ctl_dec = CTL_STORE;  imm_sel = IMM_S;  rs2_used = 1'b1; end
      OP_BRANCH: begin ctl_dec = CTL_BRANCH; imm_sel = IMM_B;  rs2_used = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  assign illegal = if_id_valid & ~legal;

  // Immediate generation
  logic [XLEN-1:0] imm;

  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

  logic [XLEN-1:0] rdata1, rdata2;

  id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk_i    (clock),
    .rst_i    (reset),
    .we_i     (wb_regwrite),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_writedata),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  // ID/EX register state
  logic            valid_q, valid_d;
  ctl_t            ctl_q, ctl_d;
  logic [XLEN-1:0] npc_q, npc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [RA-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic            hz;

  // A load in EX whose destination feeds the instruction in ID must wait one cycle.
  assign hz = if_id_valid & valid_q & ctl_q.m[M_MEMREAD] & (rd_q != '0) &
              ((rd_q == rs1) | (rs2_used & (rd_q == rs2)));
  assign stall = hz & ~flush;

  always_comb begin
    valid_d = 1'b0;
    ctl_d   = CTL_NONE;
    npc_d   = '0;
    rd1_d   = '0;
    rd2_d   = '0;
    imm_d   = '0;
    rs1_d   = '0;
    rs2_d   = '0;
    rd_d    = '0;
    // Flush and hazard both insert a bubble; otherwise take the decoded instruction.
    if (!(flush || hz)) begin
      valid_d = if_id_valid & ~illegal;
      ctl_d   = if_id_valid ? ctl_dec : CTL_NONE;
      npc_d   = if_id_npc;
      rd1_d   = rdata1;
      rd2_d   = rdata2;
      imm_d   = imm;
      rs1_d   = rs1;
      rs2_d   = rs2;
      rd_d    = rd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctl_q   <= CTL_NONE;
      npc_q   <= RESET_PC;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      npc_q   <= npc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign id_ex_valid = valid_q;
  assign wb_ctl      = ctl_q.wb;
  assign m_ctl       = ctl_q.m;
  assign ex_ctl      = ctl_q.ex;
  assign npc_out     = npc_q;
  assign rdata1_out  = rd1_q;
  assign rdata2_out  = rd2_q;
  assign imm_out     = imm_q;
  assign rs1_out     = rs1_q;
  assign rs2_out     = rs2_q;
  assign rd_out      = rd_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: expected ID/EX contents are queued when an
// instruction is driven and compared one clock later.
module tb_id_stage_hz;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_npc;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_writedata;
  logic        flush;
  logic        stall, illegal, id_ex_valid;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl, ex_ctl;
  logic [31:0] npc_out, rdata1_out, rdata2_out, imm_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [2:0]  ex;
    logic [31:0] npc, r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
    bit          data;
  } exp_t;

  exp_t sb[$];

  id_stage_hz #(.XLEN(32), .NREGS(32), .RESET_PC(RST_PC)) dut (
    .clock             (clk),
    .reset             (rst),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_npc         (if_id_npc),
    .wb_regwrite       (wb_regwrite),
    .wb_rd             (wb_rd),
    .wb_writedata      (wb_writedata),
    .flush             (flush),
    .stall             (stall),
    .illegal           (illegal),
    .id_ex_valid       (id_ex_valid),
    .wb_ctl            (wb_ctl),
    .m_ctl             (m_ctl),
    .ex_ctl            (ex_ctl),
    .npc_out           (npc_out),
    .rdata1_out        (rdata1_out),
    .rdata2_out        (rdata2_out),
    .imm_out           (imm_out),
    .rs1_out           (rs1_out),
    .rs2_out           (rs2_out),
    .rd_out            (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [1:0] wb, input logic [2:0] m,
                      input logic [2:0] ex, input logic [31:0] npc, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input bit data);
    exp_t e;
    e.v = v; e.wb = wb; e.m = m; e.ex = ex; e.npc = npc; e.r1 = r1; e.r2 = r2;
    e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push(1'b0, 2'b00, 3'b000, 3'b000, '0, '0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic push_reset();
    push(1'b0, 2'b00, 3'b000, 3'b000, RST_PC, '0, '0, '0, '0, '0, '0, 1'b1);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_queue: observed size 0 expected nonzero", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, id_ex_valid}, {31'd0, e.v});
      chk({tag, "_wb"},    {30'd0, wb_ctl},      {30'd0, e.wb});
      chk({tag, "_m"},     {29'd0, m_ctl},       {29'd0, e.m});
      chk({tag, "_ex"},    {29'd0, ex_ctl},      {29'd0, e.ex});
      if (e.data) begin
        chk({tag, "_npc"}, npc_out,    e.npc);
        chk({tag, "_rd1"}, rdata1_out, e.r1);
        chk({tag, "_rd2"}, rdata2_out, e.r2);
        chk({tag, "_imm"}, imm_out,    e.imm);
        chk({tag, "_rs1"}, {27'd0, rs1_out}, {27'd0, e.rs1});
        chk({tag, "_rs2"}, {27'd0, rs2_out}, {27'd0, e.rs2});
        chk({tag, "_rd"},  {27'd0, rd_out},  {27'd0, e.rd});
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic fl);
    if_id_valid       = v;
    if_id_instruction = ins;
    if_id_npc         = npc;
    wb_regwrite       = we;
    wb_rd             = wrd;
    wb_writedata      = wd;
    flush             = fl;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #2;
    push_reset();
    compare("reset");
    chk("reset_stall", {31'd0, stall}, 32'd0);
    cycle();
    rst = 1'b0;

    // addi x5,x0,-1
    drive(1'b1, 32'hFFF00293, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("addi_stall", {31'd0, stall}, 32'd0);
    chk("addi_illegal", {31'd0, illegal}, 32'd0);
    push(1'b1, 2'b10, 3'b000, 3'b110, 32'h104, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd5, 1'b1);
    cycle(); compare("addi");

    // lw x6,0(x5) while WB writes x5 (write-through on rs1)
    drive(1'b1, 32'h0002A303, 32'h108, 1'b1, 5'd5, 32'h0000_A5A5, 1'b0);
    chk("lw1_stall", {31'd0, stall}, 32'd0);
    push(1'b1, 2'b11, 3'b010, 3'b100, 32'h108, 32'h0000_A5A5, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b1);
    cycle(); compare("lw1");

    // add x7,x6,x6 right behind the load: one stall, bubble into ID/EX
    drive(1'b1, 32'h006303B3, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    push_bubble();
    cycle(); compare("lu_bubble");

    // Same add held in IF/ID; stall gone, WB writes x6 (write-through on both ports)
    drive(1'b1, 32'h006303B3, 32'h10C, 1'b1, 5'd6, 32'h0000_0066, 1'b0);
    chk("lu_release_stall", {31'd0, stall}, 32'd0);
    push(1'b1, 2'b10, 3'b000, 3'b010, 32'h10C, 32'h66, 32'h66, 32'h0, 5'd6, 5'd6, 5'd7, 1'b1);
    cycle(); compare("add_after_stall");

    // add x8,x3,x0 with WB writing x3
    drive(1'b1, 32'h00018433, 32'h110, 1'b1, 5'd3, 32'h0000_1234, 1'b0);
    push(1'b1, 2'b10, 3'b000, 3'b010, 32'h110, 32'h1234, 32'h0, 32'h0, 5'd3, 5'd0, 5'd8, 1'b1);
    cycle(); compare("wt_x3");

    // Same add with WB targeting x0: x0 must still read 0, x3 kept its value
    drive(1'b1, 32'h00018433, 32'h114, 1'b1, 5'd0, 32'h0000_DEAD, 1'b0);
    push(1'b1, 2'b10, 3'b000, 3'b010, 32'h114, 32'h1234, 32'h0, 32'h0, 5'd3, 5'd0, 5'd8, 1'b1);
    cycle(); compare("wt_x0");

    // Load again, then the dependent add arrives together with a flush
    drive(1'b1, 32'h0002A303, 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);
    push(1'b1, 2'b11, 3'b010, 3'b100, 32'h118, 32'h0000_A5A5, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b1);
    cycle(); compare("lw2");

    drive(1'b1, 32'h006303B3, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    push_bubble();
    cycle(); compare("flush_bubble");

    // beq x0,x0,-4
    drive(1'b1, 32'hFE000EE3, 32'h120, 1'b0, 5'd0, 32'h0, 1'b0);
    push(1'b1, 2'b00, 3'b100, 3'b001, 32'h120, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd29, 1'b1);
    cycle(); compare("beq");

    // Unknown opcode 0x7F
    drive(1'b1, 32'h0000007F, 32'h124, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("illegal_flag", {31'd0, illegal}, 32'd1);
    push_bubble();
    cycle(); compare("illegal");

    // sw x5,-8(x3)
    drive(1'b1, 32'hFE51AC23, 32'h128, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("sw_illegal", {31'd0, illegal}, 32'd0);
    push(1'b1, 2'b00, 3'b001, 3'b100, 32'h128, 32'h1234, 32'h0000_A5A5, 32'hFFFF_FFF8, 5'd3, 5'd5, 5'd24, 1'b1);
    cycle(); compare("sw");

    // lw x9,4(x3), then addi x10,x0,9 whose unused rs2 field equals 9: no stall
    drive(1'b1, 32'h0041A483, 32'h12C, 1'b0, 5'd0, 32'h0, 1'b0);
    push(1'b1, 2'b11, 3'b010, 3'b100, 32'h12C, 32'h1234, 32'h0, 32'h4, 5'd3, 5'd4, 5'd9, 1'b1);
    cycle(); compare("lw3");

    drive(1'b1, 32'h00900513, 32'h130, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("rs2_unused_stall", {31'd0, stall}, 32'd0);
    push(1'b1, 2'b10, 3'b000, 3'b110, 32'h130, 32'h0, 32'h0, 32'h9, 5'd0, 5'd9, 5'd10, 1'b1);
    cycle(); compare("addi_rs2");

    // Reset asserted during a load-use stall
    drive(1'b1, 32'h0002A303, 32'h134, 1'b0, 5'd0, 32'h0, 1'b0);
    push(1'b1, 2'b11, 3'b010, 3'b100, 32'h134, 32'h0000_A5A5, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6, 1'b1);
    cycle(); compare("lw4");

    drive(1'b1, 32'h006303B3, 32'h138, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    push_reset();
    compare("mid_rst");
    cycle();
    rst = 1'b0;

    // Register file was cleared by reset: x3 reads 0
    drive(1'b1, 32'h00018433, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
    push(1'b1, 2'b10, 3'b000, 3'b010, 32'h200, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 5'd8, 1'b1);
    cycle(); compare("post_rst_rf");

    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised RV32-style instruction-decode stage for the 5-stage pipeline.
- Contains:
  - main control decoder;
  - register file with write-through bypass;
  - immediate generator for the I, S and B formats;
  - load-use hazard detector;
  - ID/EX pipeline register with valid bit, stall-bubble and flush.
- Sits between the IF/ID register and the EX stage. Takes writeback from the WB stage and a flush from EX branch resolution.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers. Power of two; RA = log2(NREGS), at most 5.
- RESET_PC, 0, value loaded into npc_out on reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_instruction  in  32  instruction word
- if_id_npc  in  XLEN  PC+4 of the instruction
- wb_regwrite  in  1  WB write enable
- wb_rd  in  RA  WB destination register
- wb_writedata  in  XLEN  WB data
- flush  in  1  EX branch taken; kill the instruction now in ID
- stall  out  1  combinational; IF and IF/ID must hold
- illegal  out  1  combinational; valid instruction with unknown opcode
- id_ex_valid  out  1  registered
- wb_ctl  out  2  {regwrite, memtoreg}
- m_ctl  out  3  {branch, memread, memwrite}
- ex_ctl  out  3  {alusrc, aluop[1:0]}
- npc_out, rdata1_out, rdata2_out, imm_out  out  XLEN  registered
- rs1_out, rs2_out, rd_out  out  RA  registered; used by EX forwarding

Behaviour:
- Reset:
  - All outputs registered in ID/EX go to 0, except npc_out, which goes to RESET_PC.
  - All registers in the register file clear to 0.
- Field extraction:
  - opcode = instr[6:0], rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20].
  - Register indices are truncated to RA bits.
- Control decode (wb / m / ex):
  - R (0110011): 10 / 000 / 0_10
  - I-ALU (0010011): 10 / 000 / 1_10
  - LOAD (0000011): 11 / 010 / 1_00
  - STORE (0100011): 00 / 001 / 1_00
  - BRANCH (1100011): 00 / 100 / 0_01
  - Any other opcode: all controls 0; illegal = if_id_valid.
- Immediate, sign-extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - R and unknown opcodes: 0.
- Register file:
  - Write at the clock edge when wb_regwrite and wb_rd != 0.
  - Register 0 always reads 0.
  - Reads are combinational with write-through: if wb_regwrite, wb_rd == rsN and rsN != 0, readN = wb_writedata in the same cycle.
- rs2 usage: rs2 is used only by R, STORE and BRANCH. rs1 is used by all five legal types.
- Hazard condition: hz = if_id_valid & id_ex_valid & m_ctl[1] (memread) & (rd_out != 0) & ((rd_out == rs1) | (rs2 used & rd_out == rs2)).
- stall = hz & ~flush.
- Next ID/EX, priority order:
  1. reset.
  2. flush: bubble.
  3. hz: bubble.
  4. Otherwise load decoded values, with id_ex_valid = if_id_valid & ~illegal.
- Bubble definition:
  - id_ex_valid = 0 and wb_ctl, m_ctl, ex_ctl = 0.
  - Data fields: don't-care; the implementation clears them to 0.
- Invalid or illegal input: also yields zero controls.
- Latency:
  - One cycle from IF/ID to ID/EX.
  - A load-use pair costs exactly one stall cycle. On the next cycle the load has left ID/EX and hz deasserts.
- Reset asserted mid-stall: outputs clear immediately (asynchronous) and stall drops.

Decomposition:
- Package id_pkg:
  - opcode constants;
  - control field widths and bit positions;
  - a ctl struct {wb[1:0], m[2:0], ex[2:0]}.
- Sub-module id_regfile(XLEN, NREGS): register storage, x0 rule, write-through.
- Control decode, immediate generation, hazard detection and the ID/EX register stay inline.

Test Plan:
- Reset, then 0xFFF00293 (addi x5,x0,-1) with if_id_valid=1 -> next cycle: id_ex_valid=1, wb_ctl=10, ex_ctl=110, imm_out=0xFFFFFFFF, rd_out=5, rdata1_out=0.
- 0x0002A303 (lw x6,0(x5)), then 0x006303B3 (add x7,x6,x6) -> stall=1 for exactly one cycle. The ID/EX after the load is a bubble (valid=0, controls 0). The add enters ID/EX one cycle later with rs1_out=rs2_out=6.
- Decode add x8,x3,x0 while wb_regwrite=1, wb_rd=3, wb_writedata=0x1234 -> rdata1_out=0x1234 next cycle. Repeat with wb_rd=0 -> x0 stays 0.
- Same load-use pair as above, with flush=1 during the add's ID cycle -> stall=0 and ID/EX becomes a bubble.
- 0xFE000EE3 (beq x0,x0,-4) -> m_ctl=100, ex_ctl=001, imm_out=0xFFFFFFFC. Opcode 0x7F -> illegal=1, next cycle id_ex_valid=0.
- Assert reset during the stall cycle -> all ID/EX outputs 0, npc_out=RESET_PC, stall=0 in the same cycle.
